// File: rtl/skin_classifier_pipe.sv
// Two-stage skin/complexion classifier on a pixel stream with double-buffered
// thresholds (applied at start of frame) and saturating per-frame hit counters.
module skin_classifier_pipe #(
  parameter int              DW     = 10,
  parameter int              CW     = 20,
  parameter int              LAT    = 2,
  parameter logic [DW-1:0]   RST_T0 = 40,
  parameter logic [DW-1:0]   RST_T1 = 280,
  parameter logic [DW-1:0]   RST_T2 = 100,
  parameter logic [DW-1:0]   RST_T3 = 400,
  parameter logic [DW-1:0]   RST_T4 = 100,
  parameter logic [DW-1:0]   RST_T5 = 100,
  parameter logic [DW-1:0]   RST_T6 = 800
) (
  input  logic          iCLK,
  input  logic          iRST_N,
  input  logic          iValid,
  input  logic          iSOF,
  input  logic [DW-1:0] iRed,
  input  logic [DW-1:0] iGreen,
  input  logic [DW-1:0] iBlue,
  input  logic          iCfgWe,
  input  logic [2:0]    iCfgAddr,
  input  logic [DW-1:0] iCfgData,
  output logic          oValid,
  output logic [DW-1:0] oRed,
  output logic [DW-1:0] oGreen,
  output logic [DW-1:0] oBlue,
  output logic [1:0]    oIsSkin,
  output logic [CW-1:0] oCnt1,
  output logic [CW-1:0] oCnt0,
  output logic          oCntValid
);

  if (LAT != 2) begin : g_lat_check
    $error("skin_classifier_pipe: LAT must be 2");
  end

  localparam logic [DW-1:0] RST_T [7] = '{RST_T0, RST_T1, RST_T2, RST_T3,
                                          RST_T4, RST_T5, RST_T6};
  localparam logic signed [DW:0] ZERO = '0;

  logic [DW-1:0] shadow_q [7];
  logic [DW-1:0] active_q [7];
  logic [DW-1:0] thr_d    [7];
  logic [DW-1:0] thr1_q   [7];

  logic                 sof_acc;
  logic                 v1_q, sof1_q;
  logic [DW-1:0]        r1_q, g1_q, b1_q;
  logic signed [DW:0]   drg_d, dgr_d, drg1_q, dgr1_q;
  logic signed [DW:0]   rg_lo, rg_hi, gr_hi;
  logic                 c1, c0;

  logic                 valid_q, cntv_q;
  logic [DW-1:0]        red_q, green_q, blue_q;
  logic [1:0]           skin_q;
  logic [CW-1:0]        cnt1_q, cnt0_q, ocnt1_q, ocnt0_q;

  assign sof_acc = iValid && iSOF;

  // The SOF pixel must see the freshly promoted values, while pixels of the
  // closing frame still in flight keep theirs: thresholds travel with the pixel.
  always_comb begin
    for (int i = 0; i < 7; i++) begin
      thr_d[i] = sof_acc ? shadow_q[i] : active_q[i];
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      for (int i = 0; i < 7; i++) begin
        shadow_q[i] <= RST_T[i];
        active_q[i] <= RST_T[i];
      end
    end else begin
      for (int i = 0; i < 7; i++) begin
        if (iCfgWe && iCfgAddr == 3'(i)) shadow_q[i] <= iCfgData;
        if (sof_acc) active_q[i] <= shadow_q[i];
      end
    end
  end

  // Stage 1: register pixel, compute signed differences (no unsigned wrap).
  assign drg_d = $signed({1'b0, iRed})   - $signed({1'b0, iGreen});
  assign dgr_d = $signed({1'b0, iGreen}) - $signed({1'b0, iRed});

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      v1_q   <= 1'b0;
      sof1_q <= 1'b0;
      r1_q   <= '0;
      g1_q   <= '0;
      b1_q   <= '0;
      drg1_q <= '0;
      dgr1_q <= '0;
      for (int i = 0; i < 7; i++) thr1_q[i] <= RST_T[i];
    end else begin
      v1_q   <= iValid;
      sof1_q <= sof_acc;
      r1_q   <= iRed;
      g1_q   <= iGreen;
      b1_q   <= iBlue;
      drg1_q <= drg_d;
      dgr1_q <= dgr_d;
      for (int i = 0; i < 7; i++) thr1_q[i] <= thr_d[i];
    end
  end

  // Stage 2: strict comparisons against the thresholds carried with the pixel.
  assign rg_lo = $signed({1'b0, thr1_q[0]});
  assign rg_hi = $signed({1'b0, thr1_q[1]});
  assign gr_hi = $signed({1'b0, thr1_q[5]});

  assign c1 = (drg1_q > rg_lo) && (drg1_q < rg_hi) && (g1_q > b1_q) &&
              (b1_q > thr1_q[2]) && (b1_q < thr1_q[3]) && (r1_q > thr1_q[4]);
  assign c0 = (dgr1_q > ZERO) && (dgr1_q < gr_hi) && (b1_q < thr1_q[6]);

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      valid_q <= 1'b0;
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
      skin_q  <= 2'b00;
    end else begin
      valid_q <= v1_q;
      red_q   <= r1_q;
      green_q <= g1_q;
      blue_q  <= b1_q;
      skin_q  <= v1_q ? {c1, c0} : 2'b00;
    end
  end

  // Frame close publishes the running counts; the SOF pixel seeds the new frame.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      cnt1_q  <= '0;
      cnt0_q  <= '0;
      ocnt1_q <= '0;
      ocnt0_q <= '0;
      cntv_q  <= 1'b0;
    end else begin
      cntv_q <= 1'b0;
      if (v1_q) begin
        if (sof1_q) begin
          ocnt1_q <= cnt1_q;
          ocnt0_q <= cnt0_q;
          cntv_q  <= 1'b1;
          cnt1_q  <= {{(CW-1){1'b0}}, c1};
          cnt0_q  <= {{(CW-1){1'b0}}, c0};
        end else begin
          if (c1 && cnt1_q != '1) cnt1_q <= cnt1_q + 1'b1;
          if (c0 && cnt0_q != '1) cnt0_q <= cnt0_q + 1'b1;
        end
      end
    end
  end

  assign oValid    = valid_q;
  assign oRed      = red_q;
  assign oGreen    = green_q;
  assign oBlue     = blue_q;
  assign oIsSkin   = skin_q;
  assign oCnt1     = ocnt1_q;
  assign oCnt0     = ocnt0_q;
  assign oCntValid = cntv_q;

endmodule

// File: tb/tb_skin_classifier_pipe.sv
// Scoreboard bench for skin_classifier_pipe: a reference classifier and
// threshold/counter model push expectations that are popped two cycles later.
module tb_skin_classifier_pipe;

  localparam int DW = 10;
  localparam int EW = 4 + 3 * DW;

  logic          iCLK = 1'b0;
  logic          iRST_N;
  logic          iValid, iSOF, iCfgWe;
  logic [DW-1:0] iRed, iGreen, iBlue, iCfgData;
  logic [2:0]    iCfgAddr;

  logic          oValid, oCntValid;
  logic [DW-1:0] oRed, oGreen, oBlue;
  logic [1:0]    oIsSkin;
  logic [19:0]   oCnt1, oCnt0;

  logic          s_oValid, s_oCntValid;
  logic [DW-1:0] s_oRed, s_oGreen, s_oBlue;
  logic [1:0]    s_oIsSkin;
  logic [3:0]    s_oCnt1, s_oCnt0;

  int checks = 0;
  int errors = 0;

  logic [EW-1:0] exp_q [$];
  logic [63:0]   cnt_q [$];

  int shadow_m [7];
  int active_m [7];
  int m_cnt1, m_cnt0;
  int rst_t [7] = '{40, 280, 100, 400, 100, 100, 800};

  skin_classifier_pipe #(.DW(DW), .CW(20), .LAT(2)) u_dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .iValid(iValid), .iSOF(iSOF),
    .iRed(iRed), .iGreen(iGreen), .iBlue(iBlue),
    .iCfgWe(iCfgWe), .iCfgAddr(iCfgAddr), .iCfgData(iCfgData),
    .oValid(oValid), .oRed(oRed), .oGreen(oGreen), .oBlue(oBlue),
    .oIsSkin(oIsSkin), .oCnt1(oCnt1), .oCnt0(oCnt0), .oCntValid(oCntValid)
  );

  skin_classifier_pipe #(.DW(DW), .CW(4), .LAT(2)) u_dut_small (
    .iCLK(iCLK), .iRST_N(iRST_N), .iValid(iValid), .iSOF(iSOF),
    .iRed(iRed), .iGreen(iGreen), .iBlue(iBlue),
    .iCfgWe(iCfgWe), .iCfgAddr(iCfgAddr), .iCfgData(iCfgData),
    .oValid(s_oValid), .oRed(s_oRed), .oGreen(s_oGreen), .oBlue(s_oBlue),
    .oIsSkin(s_oIsSkin), .oCnt1(s_oCnt1), .oCnt0(s_oCnt0), .oCntValid(s_oCntValid)
  );

  // Clock / reset
  always #5 iCLK = ~iCLK;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, act, act, exp, exp);
    end
  endtask

  function automatic logic [1:0] classify(input int r, input int g, input int b);
    logic c1, c0;
    c1 = (r - g > active_m[0]) && (r - g < active_m[1]) && (g > b) &&
         (b > active_m[2]) && (b < active_m[3]) && (r > active_m[4]);
    c0 = (g - r > 0) && (g - r < active_m[5]) && (b < active_m[6]);
    return {c1, c0};
  endfunction

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    cnt_q.delete();
    m_cnt1 = 0;
    m_cnt0 = 0;
    for (int i = 0; i < 7; i++) begin
      shadow_m[i] = rst_t[i];
      active_m[i] = rst_t[i];
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_valid"}, 64'(oValid), 64'd0);
    check({tag, "_rgb"}, 64'({oRed, oGreen, oBlue}), 64'd0);
    check({tag, "_skin"}, 64'(oIsSkin), 64'd0);
    check({tag, "_cnt"}, 64'({oCnt1, oCnt0}), 64'd0);
    check({tag, "_cntv"}, 64'(oCntValid), 64'd0);
    check({tag, "_small_cnt"}, 64'({s_oCnt1, s_oCnt0, s_oCntValid}), 64'd0);
  endtask

  // Scoreboard: pop the entry for the pixel driven two cycles ago.
  task automatic check_output();
    logic [EW-1:0] e;
    logic [63:0]   c;
    logic          e_sof, e_v;
    logic [1:0]    e_cls;
    if (exp_q.size() < 2) return;
    e     = exp_q.pop_front();
    e_sof = e[EW-1];
    e_v   = e[EW-2];
    e_cls = e[EW-3:EW-4];
    check("out_valid", 64'(oValid), 64'(e_v));
    check("out_skin", 64'(oIsSkin), 64'(e_cls));
    check("small_skin", 64'(s_oIsSkin), 64'(e_cls));
    if (e_v) check("out_rgb", 64'({oRed, oGreen, oBlue}), 64'(e[3*DW-1:0]));
    check("cnt_valid", 64'(oCntValid), 64'(e_sof));
    check("small_cnt_valid", 64'(s_oCntValid), 64'(e_sof));
    if (e_sof) begin
      if (cnt_q.size() == 0) begin
        check("cnt_queue_empty", 64'd0, 64'd1);
      end else begin
        c = cnt_q.pop_front();
        check("cnt1", 64'(oCnt1), 64'(sat(int'(c[63:32]), (1 << 20) - 1)));
        check("cnt0", 64'(oCnt0), 64'(sat(int'(c[31:0]), (1 << 20) - 1)));
        check("small_cnt1", 64'(s_oCnt1), 64'(sat(int'(c[63:32]), 15)));
        check("small_cnt0", 64'(s_oCnt0), 64'(sat(int'(c[31:0]), 15)));
      end
    end
  endtask

  // Driver: one pixel slot per call, with optional config write in the same cycle.
  task automatic drive(input bit v, input bit sof, input int r, input int g, input int b,
                       input bit we = 0, input int addr = 0, input int data = 0);
    logic [1:0] cls;
    bit         sof_eff;
    @(negedge iCLK);
    check_output();
    iValid   = v;
    iSOF     = sof;
    iRed     = r[DW-1:0];
    iGreen   = g[DW-1:0];
    iBlue    = b[DW-1:0];
    iCfgWe   = we;
    iCfgAddr = addr[2:0];
    iCfgData = data[DW-1:0];
    sof_eff = v && sof;
    if (sof_eff) for (int i = 0; i < 7; i++) active_m[i] = shadow_m[i];
    cls = v ? classify(r, g, b) : 2'b00;
    if (sof_eff) begin
      cnt_q.push_back({32'(m_cnt1), 32'(m_cnt0)});
      m_cnt1 = int'(cls[1]);
      m_cnt0 = int'(cls[0]);
    end else if (v) begin
      m_cnt1 += int'(cls[1]);
      m_cnt0 += int'(cls[0]);
    end
    if (we && addr != 7) shadow_m[addr] = data;
    exp_q.push_back({sof_eff, v, cls, r[DW-1:0], g[DW-1:0], b[DW-1:0]});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0);
  endtask

  initial begin
    iRST_N = 1'b0;
    iValid = 0; iSOF = 0; iRed = '0; iGreen = '0; iBlue = '0;
    iCfgWe = 0; iCfgAddr = '0; iCfgData = '0;
    model_reset();
    repeat (3) @(negedge iCLK);
    #1 check_zero_outputs("reset");
    @(negedge iCLK);
    iRST_N = 1'b1;

    // Basic classes, RGB echo, bubbles and the unsigned-wrap case.
    drive(1, 0, 500, 400, 200);
    drive(1, 0, 300, 350, 100);
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 100, 400, 50);
    drive(1, 0, 10, 900, 5);
    drive(1, 0, 141, 100, 99);
    drive(1, 0, 141, 100, 101);
    idle(2);

    // 1000-pixel frame: 37 warm, 5 green-bias hits, rest no-hit; then close it.
    drive(1, 1, 0, 0, 0);
    for (int i = 1; i < 1000; i++) begin
      if ($urandom_range(0, 7) == 0) drive(0, 0, 0, 0, 0);
      if (i <= 37)      drive(1, 0, 500, 400, 200);
      else if (i <= 42) drive(1, 0, 300, 350, 100);
      else              drive(1, 0, $urandom_range(0, 1023), $urandom_range(0, 1023), 1023);
    end
    drive(1, 1, 0, 0, 0);

    // Mid-frame T0 write stays inert until the next SOF; address 7 is ignored.
    drive(1, 0, 500, 400, 200, 1, 0, 200);
    drive(1, 0, 500, 400, 200, 1, 7, 0);
    drive(1, 0, 500, 400, 200);
    drive(1, 1, 500, 400, 200);
    drive(1, 0, 500, 400, 200);

    // Write coinciding with SOF reaches only the shadow copy.
    for (int i = 0; i < 20; i++) drive(1, 0, 600, 400, 200);
    drive(1, 1, 500, 400, 200, 1, 0, 40);
    drive(1, 0, 500, 400, 200);
    drive(1, 1, 500, 400, 200);
    for (int i = 0; i < 20; i++) drive(1, 0, 500, 400, 200);
    drive(1, 0, 300, 350, 100);

    // Asynchronous reset mid-frame: outputs clear with no clock edge.
    #2 iRST_N = 1'b0;
    #1 check_zero_outputs("async_reset");
    model_reset();
    iValid = 0; iSOF = 0; iCfgWe = 0;
    repeat (2) @(negedge iCLK);
    iRST_N = 1'b1;

    for (int i = 0; i < 40; i++) begin
      drive(1, (i == 0), $urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 1023));
      if (i % 5 == 0) drive(1, 0, 500, 400, 200);
      if (i % 9 == 0) drive(1, 0, 300, 350, 100);
    end
    drive(1, 1, 300, 350, 100);
    idle(3);
    check("queue_drained", 64'(exp_q.size()), 64'd2);
    check("cnt_queue_drained", 64'(cnt_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
